serial_tx: RTL
==============

SERIAL_TX -- requirements
Module: serial_tx

Interface
REQ-001 SHALL provide parameter WIDTH, default 4, number of data bits per frame (legal range 2..16).
REQ-002 SHALL provide parameter MSB_FIRST, default 1; 1 = data sent MSB first, 0 = LSB first.
REQ-003 SHALL have port Clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port Rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port In_Valid  input  1  word offered on In_Data.
REQ-006 SHALL have port In_Data  input  WIDTH  parallel word to transmit.
REQ-007 SHALL have port In_Ready  output  1  block can accept a word this cycle.
REQ-008 SHALL have port D  output  1  serial line, driven directly from a flop; idle level 1.
REQ-009 SHALL have port Busy  output  1  frame in progress (any state other than IDLE).
REQ-010 SHALL have port Done  output  1  high exactly during the STOP cycle of each frame.

Function
REQ-011 SHALL implement states IDLE, START, DATA, PARITY (macro only), STOP.
REQ-012 Handshake: word accepted on a rising edge where In_Valid=1 and In_Ready=1; In_Ready = 1 in IDLE and STOP, else 0.
REQ-013 On acceptance SHALL latch In_Data into an internal shift register; later In_Data changes SHALL NOT affect the frame.
REQ-014 IDLE: D=1; stays IDLE while In_Valid=0; on acceptance -> START.
REQ-015 START: D=0 for exactly 1 cycle, beginning the cycle after the accepting edge; -> DATA.
REQ-016 DATA: D carries one data bit per cycle for exactly WIDTH cycles, order per MSB_FIRST; bit counter wraps to 0 at exit; -> PARITY if macro defined, else -> STOP.
REQ-017 STOP: D=1 for 1 cycle, Done=1; on acceptance in this cycle -> START (back-to-back, no idle gap), else -> IDLE.
REQ-018 Frame length SHALL be WIDTH+2 cycles (WIDTH+3 with parity); line never glitches between bits.
REQ-019 Busy SHALL be 1 in START, DATA, PARITY, STOP; 0 in IDLE.

Reset
REQ-020 Rst=1 SHALL immediately (no clock) force state IDLE, D=1, Busy=0, Done=0, bit counter 0, shift register 0.
REQ-021 Reset mid-frame SHALL abandon the frame; no partial bits resume; first edge after Rst falls behaves as IDLE.
REQ-022 In_Ready SHALL read 1 while in reset (state IDLE) but no word SHALL be accepted while Rst=1.

Configuration
REQ-023 Macro SERIAL_TX_PARITY_EN: when defined, PARITY state inserted after DATA, D = even parity bit (XOR of all WIDTH latched bits) for 1 cycle; when undefined, no PARITY state, no parity logic, DATA -> STOP.

Verification
REQ-024 WIDTH=4, MSB_FIRST=1, no parity: accept 4'b1011 -> D = 0,1,0,1,1,1 over 6 cycles, Done=1 in 6th, then D=1 idle, Busy=0.
REQ-025 Back-to-back: In_Valid held, 4'hA then 4'h5 -> D = 0,1,0,1,0,1,0,0,1,0,1,1 with no idle cycle; Done pulses at cycles 6 and 12.
REQ-026 SERIAL_TX_PARITY_EN defined: accept 4'b0111 -> D = 0,0,1,1,1,1,1 (parity bit 1), Done in 7th cycle.
REQ-027 Rst pulsed during 3rd data bit -> D=1, Busy=0 before next edge; subsequent 4'h3 frame is complete and correct: 0,0,0,1,1,1.
REQ-028 MSB_FIRST=0: accept 4'b0001 -> D = 0,1,0,0,0,1.
REQ-029 In_Data changed to 4'hF after acceptance of 4'h0 -> D = 0,0,0,0,0,1 (changes ignored).

Source files
------------

// File: rtl/serial_tx_if.sv
// serial_tx_if -- handshake and line bundle for serial_tx.
//   master : drives In_Valid/In_Data, observes In_Ready, D, Busy, Done
//   slave  : the transmitter side
interface serial_tx_if #(parameter int WIDTH = 4);
   logic             In_Valid;   // word offered
   logic [WIDTH-1:0] In_Data;    // parallel word
   logic             In_Ready;   // transmitter can take a word this cycle
   logic             D;          // serial line, idle high
   logic             Busy;       // frame in progress
   logic             Done;       // STOP cycle of a frame

   modport master (output In_Valid, In_Data, input In_Ready, D, Busy, Done);
   modport slave  (input In_Valid, In_Data, output In_Ready, D, Busy, Done);
endinterface

// File: rtl/serial_tx.sv
// serial_tx -- parallel-in, framed serial-out transmitter.
// Frame: START(0), WIDTH data bits (MSB or LSB first), optional even parity
// bit, STOP(1). A word offered during STOP starts the next frame with no gap.
// Ports:
//   Clk  : clock, rising edge
//   Rst  : asynchronous active-high reset
//   bus  : serial_tx_if.slave (In_Valid, In_Data, In_Ready, D, Busy, Done)
// Parameters: WIDTH (2..16) data bits per frame, MSB_FIRST (1 = MSB first).
// Build option: define SERIAL_TX_PARITY_EN to insert the parity bit.
module serial_tx #(
   parameter int WIDTH     = 4,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic        Clk,
   input  logic        Rst,
   serial_tx_if.slave  bus
);

   localparam int           CW   = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

`ifdef SERIAL_TX_PARITY_EN
   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] sh_q, sh_d;
   logic             d_q, d_d;
`ifdef SERIAL_TX_PARITY_EN
   logic             par_q, par_d;
`endif

   logic             in_ready;
   logic             accept;
   logic             sh_out;
   logic [WIDTH-1:0] sh_next;

   // Bit leaving the shift register and the register after it has gone;
   // vacated positions fill with zero.
   generate
      if (MSB_FIRST) begin : g_msb
         assign sh_out  = sh_q[WIDTH-1];
         assign sh_next = {sh_q[WIDTH-2:0], 1'b0};
      end else begin : g_lsb
         assign sh_out  = sh_q[0];
         assign sh_next = {1'b0, sh_q[WIDTH-1:1]};
      end
   endgenerate

   // Reset dominates every flop, so nothing can be accepted while Rst is high
   // even though In_Ready reads 1 in IDLE.
   assign accept = bus.In_Valid & in_ready;

   // State register
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         sh_q    <= '0;
         d_q     <= 1'b1;
`ifdef SERIAL_TX_PARITY_EN
         par_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sh_q    <= sh_d;
         d_q     <= d_d;
`ifdef SERIAL_TX_PARITY_EN
         par_q   <= par_d;
`endif
      end
   end

   // Next state; d_d is the line level for the state being entered so the
   // line comes straight from a flop.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      sh_d    = sh_q;
      d_d     = d_q;
`ifdef SERIAL_TX_PARITY_EN
      par_d   = par_q;
`endif
      case (state_q)
         S_IDLE, S_STOP: begin
            if (accept) begin
               state_d = S_START;
               sh_d    = bus.In_Data;
               d_d     = 1'b0;
`ifdef SERIAL_TX_PARITY_EN
               // Parity taken from the word as latched; the shift register
               // is consumed during DATA.
               par_d   = ^bus.In_Data;
`endif
            end else begin
               state_d = S_IDLE;
               d_d     = 1'b1;
            end
         end
         S_START: begin
            state_d = S_DATA;
            cnt_d   = '0;
            d_d     = sh_out;
            sh_d    = sh_next;
         end
         S_DATA: begin
            if (cnt_q == LAST) begin
               cnt_d   = '0;
`ifdef SERIAL_TX_PARITY_EN
               state_d = S_PARITY;
               d_d     = par_q;
`else
               state_d = S_STOP;
               d_d     = 1'b1;
`endif
            end else begin
               cnt_d = cnt_q + 1'b1;
               d_d   = sh_out;
               sh_d  = sh_next;
            end
         end
`ifdef SERIAL_TX_PARITY_EN
         S_PARITY: begin
            state_d = S_STOP;
            d_d     = 1'b1;
         end
`endif
         default: begin
            state_d = S_IDLE;
            d_d     = 1'b1;
         end
      endcase
   end

   // Outputs
   always_comb begin
      in_ready     = (state_q == S_IDLE) || (state_q == S_STOP);
      bus.In_Ready = in_ready;
      bus.Busy     = (state_q != S_IDLE);
      bus.Done     = (state_q == S_STOP);
      bus.D        = d_q;
   end

endmodule
